// File: rtl/socaudio_div_pkg.sv
// Shared definitions for the Nios II sequential divider cell.
// Contents:
//   DivDataW     - default operand / result width
//   DivCntW      - step-counter width for the default width
//   div_state_e  - divider FSM states
package socaudio_div_pkg;

  localparam int unsigned DivDataW = 32;
  localparam int unsigned DivCntW  = $clog2(DivDataW);

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/socaudio_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i, quot_i  - partial remainder and quotient/dividend shift register
//   divisor_i      - divisor magnitude
//   rem_o, quot_o  - partial remainder and quotient after this step
module socaudio_div_step
  import socaudio_div_pkg::*;
#(
  parameter int unsigned DATA_W = DivDataW
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  always_comb begin
    // Shift the next dividend bit out of the quotient register into the remainder.
    shifted = {rem_i, quot_i[DATA_W-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[DATA_W]) begin
      rem_o  = trial[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o  = shifted[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/socaudio_nios_div_cell.sv
// Sequential restoring integer divider for the Nios II E/M stages.
// One quotient bit per clock; fixed latency of DATA_W+2 cycles from an accepted start.
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   E_src1, E_src2  - dividend, divisor (sampled on an accepted start)
//   div_start       - request, accepted while div_busy is low
//   div_signed      - two's-complement operands when high
//   M_div_quot      - quotient of the last division
//   M_div_rem       - remainder of the last division
//   M_div_by_zero   - last divisor was zero
//   div_busy        - division in flight, starts are dropped
//   div_done        - one-cycle pulse when results become valid
module socaudio_nios_div_cell
  import socaudio_div_pkg::*;
#(
  parameter int unsigned DATA_W = DivDataW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              div_start,
  input  logic              div_signed,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_by_zero,
  output logic              div_busy,
  output logic              div_done
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  div_state_e        state_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic              sgn_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              zero_div_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] dvsr_q;
  logic [CntW-1:0]   cnt_q;

  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quot_nxt;
  logic [DATA_W-1:0] fix_quot;
  logic [DATA_W-1:0] fix_rem;

  // Wrap-around negation maps -2^(W-1) onto itself, which is its correct unsigned magnitude.
  assign mag1 = (sgn_q && src1_q[DATA_W-1]) ? -src1_q : src1_q;
  assign mag2 = (sgn_q && src2_q[DATA_W-1]) ? -src2_q : src2_q;

  socaudio_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_nxt),
    .quot_o    (quot_nxt)
  );

  // Signed overflow (-2^(W-1) / -1) needs no special case: the negation wraps to 0x80..0.
  always_comb begin
    if (zero_div_q) begin
      fix_quot = '1;
      fix_rem  = src1_q;
    end else begin
      fix_quot = q_neg_q ? -quot_q : quot_q;
      fix_rem  = r_neg_q ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      src1_q        <= '0;
      src2_q        <= '0;
      sgn_q         <= 1'b0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      zero_div_q    <= 1'b0;
      rem_q         <= '0;
      quot_q        <= '0;
      dvsr_q        <= '0;
      cnt_q         <= '0;
      M_div_quot    <= '0;
      M_div_rem     <= '0;
      M_div_by_zero <= 1'b0;
      div_busy      <= 1'b0;
      div_done      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_start) begin
            src1_q   <= E_src1;
            src2_q   <= E_src2;
            sgn_q    <= div_signed;
            div_busy <= 1'b1;
            state_q  <= StPrep;
          end
        end
        StPrep: begin
          q_neg_q    <= sgn_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
          r_neg_q    <= sgn_q & src1_q[DATA_W-1];
          quot_q     <= mag1;
          dvsr_q     <= mag2;
          rem_q      <= '0;
          zero_div_q <= (src2_q == '0);
          cnt_q      <= '0;
          state_q    <= StIter;
        end
        StIter: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          M_div_quot    <= fix_quot;
          M_div_rem     <= fix_rem;
          M_div_by_zero <= zero_div_q;
          div_busy      <= 1'b0;
          div_done      <= 1'b1;
          state_q       <= StDone;
        end
        StDone: begin
          div_done <= 1'b0;
          if (div_start) begin
            src1_q   <= E_src1;
            src2_q   <= E_src2;
            sgn_q    <= div_signed;
            div_busy <= 1'b1;
            state_q  <= StPrep;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          div_busy <= 1'b0;
          div_done <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule
